// File: rtl/apb4_master_if.sv
// APB4 requester bundle: command stream, response stream and APB bus.
// master = requester side, slave = controller/bus side.
interface apb4_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [31:0] paddr;
  logic [2:0]  pprot;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        psel;
  logic        penable;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    input  cmd_valid, cmd_addr, cmd_write,
    input  cmd_wdata, cmd_strb, cmd_prot,
    input  rsp_ready, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata,
    output rsp_err, rsp_timeout,
    output paddr, pprot, pwrite, pwdata,
    output pstrb, psel, penable
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_write,
    output cmd_wdata, cmd_strb, cmd_prot,
    output rsp_ready, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata,
    input  rsp_err, rsp_timeout,
    input  paddr, pprot, pwrite, pwdata,
    input  pstrb, psel, penable
  );
endinterface

// File: rtl/apb4_master.sv
// APB4 requester: one outstanding transfer, wait states,
// PSLVERR reporting and a stuck-slave timeout abort.
module apb4_master #(
  parameter int unsigned TIMEOUT = 256
) (
  input logic         pclk,
  input logic         preset,
  apb4_master_if.master bus
);

  localparam int CW =
    (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST =
    (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE, SETUP, ACCESS, RESP
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        psel_q, psel_d;
  logic        penable_q, penable_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_to_q, rsp_to_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic [3:0]  pstrb_q, pstrb_d;
  logic [2:0]  pprot_q, pprot_d;
  logic        pwrite_q, pwrite_d;
  logic        timed_out;

  // Last pending cycle before the limit is reached
  assign timed_out =
    (TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
      rdata_q     <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      pprot_q     <= '0;
      pwrite_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_to_q    <= rsp_to_d;
      rdata_q     <= rdata_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      pprot_q     <= pprot_d;
      pwrite_q    <= pwrite_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_ready_d = cmd_ready_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_to_d    = rsp_to_q;
    rdata_d     = rdata_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    pprot_d     = pprot_q;
    pwrite_d    = pwrite_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          state_d     = SETUP;
          cmd_ready_d = 1'b0;
          psel_d      = 1'b1;
          cnt_d       = '0;
          paddr_d     = bus.cmd_addr;
          pwrite_d    = bus.cmd_write;
          pprot_d     = bus.cmd_prot;
          pstrb_d     = bus.cmd_write ?
                        bus.cmd_strb : 4'h0;
          pwdata_d    = bus.cmd_write ?
                        bus.cmd_wdata : 32'h0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (bus.pready) begin
          state_d     = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = bus.pslverr;
          rsp_to_d    = 1'b0;
          rdata_d     = pwrite_q ?
                        32'h0 : bus.prdata;
        end else if (timed_out) begin
          // Deliberate protocol exception: abandon a hung slave
          state_d     = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_to_d    = 1'b1;
          rdata_d     = 32'h0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_to_q;
  assign bus.rsp_rdata   = rdata_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.pstrb       = pstrb_q;
  assign bus.pprot       = pprot_q;
  assign bus.pwrite      = pwrite_q;

endmodule
